mem_arbiter: RTL and testbench

- Shares the core's single-port memory between the instruction-fetch requester and the load/store requester.
- Arbitrates one access per cycle and routes read data back to the owning requester.
- Checks alignment and raises misaligned faults without touching memory; these feed the fetch and load/store misaligned-exception paths in the trap/CSR logic.
- Sits between the core pipeline and the memory instance.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_resp.sv | 50 +++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and alignment/byte-enable helpers for the memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Size code 3 is undefined and always treated as misaligned.
  function automatic logic misalign(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = lo[0];
      SZ_W:    misalign = (lo != 2'b00);
      default: misalign = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    byte_en = 4'b0001 << lo;
      SZ_H:    byte_en = 4'b0011 << lo;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_resp.sv
// Response pipe: one {valid, owner, err} register, demuxed to the fetch or data port.
module mem_arb_resp
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt_valid,
  input  owner_t      gnt_owner,
  input  logic        gnt_err,
  input  logic [31:0] m_rdata,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  logic   valid_q;
  owner_t owner_q;
  logic   err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      owner_q <= OWN_I;
      err_q   <= 1'b0;
    end else begin
      valid_q <= gnt_valid;
      owner_q <= gnt_owner;
      err_q   <= gnt_err;
    end
  end

  logic        live;
  logic [31:0] rdata;

  // Gating with rst drops a response that falls due in a reset cycle.
  always_comb begin
    live     = rst && valid_q;
    rdata    = err_q ? 32'h0 : m_rdata;
    i_rvalid = live && (owner_q == OWN_I);
    d_rvalid = live && (owner_q == OWN_D);
    i_err    = i_rvalid && err_q;
    d_err    = d_rvalid && err_q;
    i_rdata  = i_rvalid ? rdata : 32'h0;
    d_rdata  = d_rvalid ? rdata : 32'h0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the single-port core memory.
// Optional tohost test-completion detector enabled by MEM_ARB_TOHOST_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MEM_AW       = 16,
  parameter int MAX_D_STREAK = 4
`ifdef MEM_ARB_TOHOST_EN
  ,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
`ifdef MEM_ARB_TOHOST_EN
  ,
  output logic              test_done,
  output logic              test_pass
`endif
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  // Upper address bits are ignored so the memory wraps.
  logic unused_addr;
  assign unused_addr = ^{i_addr[ADDR_W-1:MEM_AW+2], d_addr[ADDR_W-1:MEM_AW+2]};

  logic [SW-1:0] streak;
  logic          force_i;
  logic          i_mis;
  logic          d_mis;

  // Grant rule: data wins unless a fetch has waited out the streak budget.
  always_comb begin
    force_i = i_req && (streak == STREAK_MAX);
    d_gnt   = rst && d_req && !force_i;
    i_gnt   = rst && i_req && !d_gnt;
    i_mis   = (i_addr[1:0] != 2'b00);
    d_mis   = misalign(d_size, d_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (!i_req || i_gnt) begin
      streak <= '0;
    end else if (d_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_be    = 4'h0;
    m_wdata = 32'h0;
    if (d_gnt && !d_mis) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr[MEM_AW+1:2];
      m_be    = d_we ? byte_en(d_size, d_addr[1:0]) : 4'hF;
      m_wdata = d_wdata << {d_addr[1:0], 3'b000};
    end else if (i_gnt && !i_mis) begin
      m_en   = 1'b1;
      m_addr = i_addr[MEM_AW+1:2];
      m_be   = 4'hF;
    end
  end

  mem_arb_resp u_resp (
    .clk       (clk),
    .rst       (rst),
    .gnt_valid (i_gnt || d_gnt),
    .gnt_owner (d_gnt ? OWN_D : OWN_I),
    .gnt_err   (d_gnt ? d_mis : i_mis),
    .m_rdata   (m_rdata),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err)
  );

`ifdef MEM_ARB_TOHOST_EN
  logic tohost_hit;
  assign tohost_hit = d_gnt && d_we && (d_size == SZ_W) && !d_mis && d_wdata[0] &&
                      (d_addr == TOHOST_ADDR[ADDR_W-1:0]);

  // First qualifying store latches the verdict; later ones are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
    end else if (tohost_hit && !test_done) begin
      test_done <= 1'b1;
      test_pass <= (d_wdata == 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency memory stub.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_en, m_we;
  logic [15:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;
`ifdef MEM_ARB_TOHOST_EN
  logic        test_done, test_pass;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
`ifdef MEM_ARB_TOHOST_EN
    , .test_done(test_done), .test_pass(test_pass)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory stub: word w initially holds 32'hC0DE0000 | w.
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < 1024; w++) mem[w] <= 32'hC0DE0000 | w;
      mem_init <= 1'b1;
    end else if (m_en) begin
      m_rdata <= mem[m_addr[9:0]];
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr[9:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_size = SZ_W; d_addr = 0; d_wdata = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle();
    i_req = 1; i_addr = a;
  endtask

  task automatic data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd);
    idle();
    d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    m_rdata = 32'h0;
    rst = 0;
    fetch(32'h100);
    d_req = 1;
    tick();
    tick();
    #2;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);

    // idle after reset release
    rst = 1;
    idle();
    #2;
    chk("idle_gnt", {i_gnt, d_gnt}, 0);
    chk("idle_m_en", m_en, 0);
    tick();
    chk("idle_rvalid", {i_rvalid, d_rvalid}, 0);

    // plain fetch
    fetch(32'h100);
    #2;
    chk("f_i_gnt", i_gnt, 1);
    chk("f_m_en", m_en, 1);
    chk("f_m_addr", m_addr, 32'h40);
    tick();
    idle();
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'hC0DE0040);
    chk("f_d_rvalid", d_rvalid, 0);

    // contention: four data grants, then a forced fetch, then data again
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 0; d_size = SZ_W; d_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("st_d_gnt", d_gnt, (k != 4));
      chk("st_i_gnt", i_gnt, (k == 4));
      tick();
      chk("st_d_rvalid", d_rvalid, (k != 4));
      chk("st_i_rvalid", i_rvalid, (k == 4));
      if (k == 4) chk("st_i_rdata", i_rdata, 32'hC0DE0041);
      else        chk("st_d_rdata", d_rdata, 32'hC0DE0080);
    end
    idle();

    // misaligned fetch
    fetch(32'h102);
    #2;
    chk("mf_i_gnt", i_gnt, 1);
    chk("mf_m_en", m_en, 0);
    tick();
    idle();
    chk("mf_i_rvalid", i_rvalid, 1);
    chk("mf_i_err", i_err, 1);
    chk("mf_i_rdata", i_rdata, 0);

    // byte store to lane 3
    data(1, SZ_B, 32'h203, 32'hAB);
    #2;
    chk("sb_d_gnt", d_gnt, 1);
    chk("sb_m_we", {m_en, m_we}, 2'b11);
    chk("sb_m_be", m_be, 4'b1000);
    chk("sb_m_wdata", m_wdata, 32'hAB000000);
    chk("sb_m_addr", m_addr, 32'h80);
    tick();
    chk("sb_d_rvalid", d_rvalid, 1);
    chk("sb_d_err", d_err, 0);

    // misaligned half store immediately followed by a load of the same word
    data(1, SZ_H, 32'h201, 32'h1234);
    #2;
    chk("sh_d_gnt", d_gnt, 1);
    chk("sh_m_en", m_en, 0);
    tick();
    data(0, SZ_W, 32'h200, 0);
    chk("sh_d_rvalid", d_rvalid, 1);
    chk("sh_d_err", d_err, 1);
    chk("sh_d_rdata", d_rdata, 0);
    #2;
    chk("ld_m_be", m_be, 4'hF);
    tick();
    idle();
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_d_err", d_err, 0);
    chk("ld_d_rdata", d_rdata, 32'hABDE0080);

    // reset while a fetch response is pending
    fetch(32'h0);
    tick();
    idle();
    rst = 0;
    #2;
    chk("rp_rvalid_now", {i_rvalid, d_rvalid}, 0);
    tick();
    #2;
    chk("rp_rvalid_next", {i_rvalid, d_rvalid}, 0);
    chk("rp_outs", {i_gnt, d_gnt, m_en, m_we, i_err, d_err}, 0);
    rst = 1;
    fetch(32'h0);
    #2;
    chk("rp_i_gnt", i_gnt, 1);
    tick();
    idle();
    chk("rp_i_rvalid", i_rvalid, 1);
    chk("rp_i_rdata", i_rdata, 32'hC0DE0000);

`ifdef MEM_ARB_TOHOST_EN
    data(1, SZ_W, 32'h1000, 32'h1);
    #2;
    chk("th_pre_done", test_done, 0);
    tick();
    idle();
    chk("th_done", test_done, 1);
    chk("th_pass", test_pass, 1);
    tick();
    chk("th_hold", {test_done, test_pass}, 2'b11);
    rst = 0;
    tick();
    chk("th_rst", {test_done, test_pass}, 2'b00);
    rst = 1;
    data(1, SZ_W, 32'h1000, 32'h5);
    tick();
    idle();
    chk("th5_done", test_done, 1);
    chk("th5_pass", test_pass, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
